// File: rtl/retospect_pkg.sv
// Shared types, constants and the serial CRC-8 step for the config-chain loader.
// The chain is one clockbox followed by N_CELLS cells.
package retospect_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StVerify,
    StArm,
    StDone,
    StErr
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int unsigned CLOCKBOX_BITS  = 48;
  localparam int unsigned CELL_BITS      = 19;
  localparam int unsigned N_CELLS        = 25;
  localparam int unsigned BS_LEN_DEFAULT = CLOCKBOX_BITS + N_CELLS * CELL_BITS;

  // MSB-first serial CRC-8 update by one bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/retospect_crc8_serial.sv
// Bit-serial CRC-8 accumulator (init 0x00); clr has priority over en.
module retospect_crc8_serial
  import retospect_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      crc_q <= 8'h00;
    end else if (en) begin
      crc_q <= crc8_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/retospect_bs_loader.sv
// Byte-stream loader: serialises bytes LSB-first into the config chain, recirculates the
// chain once to check its CRC, and arms the network with a one-cycle reset_nn pulse.
module retospect_bs_loader
  import retospect_pkg::*;
#(
  parameter int unsigned BS_LEN = BS_LEN_DEFAULT,
  parameter int unsigned CNT_W  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       bs_out,
  output logic       bs_in,
  output logic       config_en,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(BS_LEN - 1);

  state_e           state_q, state_d;
  logic [7:0]       byte_q;
  logic [2:0]       bi_q;
  logic             full_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] vcnt_q;

  logic       in_shift, in_verify, start_ok;
  logic       shift_en, last_bit, final_bit, accept, verify_last, crc_match;
  logic [7:0] crc_tx, crc_rb;

  always_comb begin
    in_shift    = (state_q == StShift);
    in_verify   = (state_q == StVerify);
    start_ok    = start && (state_q inside {StIdle, StDone, StErr});
    shift_en    = in_shift && full_q;
    final_bit   = shift_en && (bit_cnt_q == LEN_M1);
    last_bit    = shift_en && ((bi_q == 3'd7) || (bit_cnt_q == LEN_M1));
    // Refill on the buffer's last bit so back-to-back bytes shift without a bubble,
    // but never once the final chain bit is going out.
    s_ready     = in_shift && (!full_q || (last_bit && !final_bit));
    accept      = s_valid && s_ready;
    verify_last = in_verify && (vcnt_q == LEN_M1);
    // Compare including the bit readback is consuming on this edge.
    crc_match   = (crc8_step(crc_rb, bs_out) == crc_tx);
    config_en   = shift_en || in_verify;
    if (in_verify) begin
      bs_in = bs_out;
    end else if (shift_en) begin
      bs_in = byte_q[bi_q];
    end else begin
      bs_in = 1'b0;
    end
    reset_nn = (state_q == StArm);
    busy     = in_shift || in_verify || (state_q == StArm);
    done     = (state_q == StDone);
    err      = (state_q == StErr);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StShift;
      StShift:               if (final_bit) state_d = StVerify;
      StVerify:              if (verify_last) state_d = crc_match ? StArm : StErr;
      StArm:                 state_d = StDone;
      default:               state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      byte_q    <= 8'h00;
      bi_q      <= 3'd0;
      full_q    <= 1'b0;
      bit_cnt_q <= '0;
      vcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        byte_q    <= 8'h00;
        bi_q      <= 3'd0;
        full_q    <= 1'b0;
        bit_cnt_q <= '0;
        vcnt_q    <= '0;
      end else begin
        if (accept) begin
          byte_q <= s_data;
          bi_q   <= 3'd0;
          full_q <= 1'b1;
        end else if (last_bit) begin
          // Unshifted high bits of the final byte are dropped here.
          full_q <= 1'b0;
        end else if (shift_en) begin
          bi_q <= bi_q + 3'd1;
        end
        if (shift_en) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        if (in_verify) vcnt_q <= vcnt_q + CNT_W'(1);
      end
    end
  end

  retospect_crc8_serial u_crc_tx (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (shift_en),
    .bit_i (bs_in),
    .crc_o (crc_tx)
  );

  retospect_crc8_serial u_crc_rb (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (in_verify),
    .bit_i (bs_out),
    .crc_o (crc_rb)
  );

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Scoreboarded bench: the chain is a BS_LEN-bit shift register; expected bits and load
// results are queued at stimulus time and checked by a negedge monitor.
module tb_retospect_bs_loader;

  localparam int L  = 523;
  localparam int L2 = 10;

  typedef struct {
    logic         done;
    logic         err;
    int           en_total;
    int           falls;
    int           rn;
    int           hs;
    logic [L-1:0] content;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, bs_out, bs_in, config_en, reset_nn, busy, done, err;
  logic start2 = 1'b0, s_valid2 = 1'b0;
  logic [7:0] s_data2 = 8'h00;
  logic s_ready2, bs_out2, bs_in2, config_en2, reset_nn2, busy2, done2, err2;

  logic [L-1:0]  chain = '0;
  logic [L2-1:0] chain2 = '0;
  logic brk = 1'b0;

  int checks = 0, failures = 0;
  int cyc = 0, en_cnt = 0, falls = 0, rn_cnt = 0, rn_cyc = 0, hs_cnt = 0;
  int en2_cnt = 0, rn2_cnt = 0;
  bit en_prev = 0, fin_seen = 0;
  logic bit_q[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  retospect_bs_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .bs_out(bs_out), .bs_in(bs_in), .config_en(config_en),
    .reset_nn(reset_nn), .busy(busy), .done(done), .err(err)
  );

  retospect_bs_loader #(.BS_LEN(L2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .s_data(s_data2), .s_valid(s_valid2),
    .s_ready(s_ready2), .bs_out(bs_out2), .bs_in(bs_in2), .config_en(config_en2),
    .reset_nn(reset_nn2), .busy(busy2), .done(done2), .err(err2)
  );

  always @(posedge clk) begin
    if (config_en) chain <= {chain[L-2:0], bs_in};
    if (config_en2) chain2 <= {chain2[L2-2:0], bs_in2};
  end
  assign bs_out  = brk ? 1'b0 : chain[L-1];
  assign bs_out2 = chain2[L2-1];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic logic [7:0] crc_stream(input logic [L-1:0] c);
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int j = 0; j < L; j++) begin
      fb = r[7] ^ c[L-1-j];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_val(input int mode, input int i);
    if (mode == 2) return (i == 0) ? 8'hA5 : 8'h00;
    return 8'(i * 29 + 7);
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic b;
    cyc++;
    if (reset || (start && !busy)) begin
      en_cnt = 0; falls = 0; rn_cnt = 0; hs_cnt = 0; en_prev = 0; fin_seen = 0;
      bit_q.delete();
    end else begin
      if (config_en) begin
        en_cnt++;
        if (en_cnt <= L) begin
          chk("bit_avail", int'(bit_q.size() != 0), 1);
          if (bit_q.size() != 0) begin
            b = bit_q.pop_front();
            chk("bs_in_bit", int'(bs_in), int'(b));
          end
        end
      end else if (en_prev) begin
        falls++;
      end
      en_prev = config_en;
      if (s_valid && s_ready) hs_cnt++;
      if (reset_nn) begin rn_cnt++; rn_cyc = cyc; end
      if ((done || err) && !fin_seen) begin
        fin_seen = 1;
        chk("exp_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("done", int'(done), int'(e.done));
          chk("err", int'(err), int'(e.err));
          chk("busy_at_end", int'(busy), 0);
          chk("config_en_cycles", en_cnt, e.en_total);
          chk("config_en_falls", falls, e.falls);
          chk("reset_nn_pulses", rn_cnt, e.rn);
          chk("handshakes", hs_cnt, e.hs);
          chk("chain_content", int'(chain == e.content), 1);
          if (e.done) chk("done_after_arm", cyc - rn_cyc, 1);
        end
      end
    end
    if (config_en2) en2_cnt++;
    if (reset_nn2) rn2_cnt++;
  end

  task automatic send_byte(input logic [7:0] d, output bit ok);
    s_data = d; s_valid = 1'b1; ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (ok) for (int k = 0; k < 8; k++) bit_q.push_back(d[k]);
  endtask

  task automatic wait_fin();
    for (int t = 0; t < 4000 && exp_q.size() != 0; t++) @(negedge clk);
    chk("finish_seen", int'(exp_q.size() == 0), 1);
  endtask

  // mode: 0 nominal, 1 stalls, 2 broken chain, 3 reset after 100 bits, 4 extra byte + start
  task automatic run_load(input int mode);
    exp_t e;
    logic [L-1:0] cont;
    logic [7:0] d;
    bit ok;
    int sb;
    brk = (mode == 2);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cont = '0; sb = 0;
    for (int i = 0; i < 66; i++) begin
      d = byte_val(mode, i);
      send_byte(d, ok);
      chk("byte_accept", int'(ok), 1);
      for (int k = 0; k < 8; k++) if (sb < L) begin cont[L-1-sb] = d[k]; sb++; end
      if (mode == 1 && i % 5 == 4) repeat (10) begin @(posedge clk); #1; end
      if (mode == 3 && i == 12) break;
    end
    if (mode == 3) begin
      for (int t = 0; t < 200 && en_cnt < 100; t++) @(negedge clk);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_config_en", int'(config_en), 0);
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_busy", int'(busy), 0);
      @(posedge clk); #1 reset = 1'b0;
    end else begin
      e.err      = (crc_stream(cont) != crc_stream(brk ? '0 : cont));
      e.done     = !e.err;
      e.en_total = 2 * L;
      e.falls    = (mode == 1) ? 14 : 1;
      e.rn       = e.done ? 1 : 0;
      e.hs       = 66;
      e.content  = brk ? '0 : cont;
      exp_q.push_back(e);
      if (mode == 4) begin
        s_data = 8'hEE; s_valid = 1'b1;
        for (int t = 0; t < 2000 && en_cnt <= L + 20; t++) @(negedge clk);
        chk("extra_s_ready", int'(s_ready), 0);
        chk("verify_busy", int'(busy), 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_fin();
      s_valid = 1'b0;
      brk = 1'b0;
    end
  endtask

  initial begin
    int hs2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_s_ready", int'(s_ready), 0);
    chk("reset_config_en", int'(config_en), 0);
    chk("reset_bs_in", int'(bs_in), 0);
    chk("reset_reset_nn", int'(reset_nn), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    @(posedge clk); #1 reset = 1'b0;

    run_load(0);
    run_load(1);
    run_load(2);
    run_load(3);
    run_load(0);
    run_load(4);

    // Short chain, all-zero stream: 16 bits offered, 10 shifted.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    s_data2 = 8'h00; s_valid2 = 1'b1; hs2 = 0;
    for (int t = 0; t < 100 && hs2 < 2; t++) begin
      @(negedge clk); if (s_ready2) hs2++;
      @(posedge clk); #1;
    end
    s_valid2 = 1'b0;
    for (int t = 0; t < 200 && !(done2 || err2); t++) @(negedge clk);
    chk("short_handshakes", hs2, 2);
    chk("short_done", int'(done2), 1);
    chk("short_err", int'(err2), 0);
    chk("short_config_en_cycles", en2_cnt, 2 * L2);
    chk("short_reset_nn", rn2_cnt, 1);
    chk("short_content", int'(chain2), 0);
    chk("short_crc_tx", int'(dut2.u_crc_tx.crc_o), 0);
    chk("short_crc_rb", int'(dut2.u_crc_rb.crc_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
